// File: rtl/button_event_pkg.sv
// Shared types and helpers for the button event detector.
// The optional auto-repeat feature is enabled by defining BUTTON_AUTOREPEAT_EN.
package button_event_pkg;

  // Gesture classifier states; encodings 5..7 are unused and recover to IDLE.
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRESSED1  = 3'd1,
    WAIT2     = 3'd2,
    PRESSED2  = 3'd3,
    LONG_HELD = 3'd4
  } btn_state_e;

  // Width of a counter that can hold the largest of the three intervals.
  function automatic int cnt_width(input int long_cycles,
                                   input int gap_cycles,
                                   input int rep_cycles);
    int m;
    m = long_cycles;
    if (gap_cycles > m) m = gap_cycles;
    if (rep_cycles > m) m = rep_cycles;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/btn_edge_detect.sv
// Polarity normalisation and edge detection of the debounced button level.
// pe_o/ne_o are combinational from the current level and the previous level.
module btn_edge_detect #(
  parameter bit IS_PULLUP = 1'b0
) (
  input  logic clk,
  input  logic rstn,
  input  logic btn_i,
  output logic pe_o,
  output logic ne_o
);

  logic btn;
  logic btn_q;  // previous normalised level (btn_d)

  assign btn = btn_i ^ IS_PULLUP;

  // Remember last cycle's level; reset treats the button as released.
  always_ff @(posedge clk) begin
    if (!rstn) btn_q <= 1'b0;
    else       btn_q <= btn;
  end

  assign pe_o = btn & ~btn_q;
  assign ne_o = ~btn & btn_q;

endmodule

// File: rtl/button_event_detector.sv
// Classifies button gestures into single-cycle event pulses
// (press, release, click, double click, long press) plus a held level.
// Define BUTTON_AUTOREPEAT_EN to add periodic o_repeat pulses while held long.
module button_event_detector
  import button_event_pkg::*;
#(
  parameter int IS_PULLUP     = 0,
  parameter int LONG_CYCLES   = 1024,
  parameter int GAP_CYCLES    = 256,
  parameter int REPEAT_CYCLES = 128
) (
  input  logic clk,
  input  logic rstn,
  input  logic i_btn,
  output logic o_press,
  output logic o_release,
  output logic o_click,
  output logic o_dclick,
  output logic o_long,
  output logic o_held,
  output logic o_repeat
);

  // Elaboration-time parameter sanity checks.
  if (LONG_CYCLES < 2)   begin : g_bad_long $error("LONG_CYCLES must be >= 2"); end
  if (GAP_CYCLES < 2)    begin : g_bad_gap  $error("GAP_CYCLES must be >= 2"); end
  if (REPEAT_CYCLES < 1) begin : g_bad_rep  $error("REPEAT_CYCLES must be >= 1"); end

`ifdef BUTTON_AUTOREPEAT_EN
  localparam int REP_FOR_W = REPEAT_CYCLES;
`else
  localparam int REP_FOR_W = 1;
`endif
  localparam int CNT_W = cnt_width(LONG_CYCLES, GAP_CYCLES, REP_FOR_W);

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

  logic pe;
  logic ne;

  btn_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cnt_clr;

  logic press_q, release_q, click_q, dclick_q, long_q, held_q;
  logic click_d, dclick_d, long_d;

  btn_edge_detect #(
    .IS_PULLUP (IS_PULLUP != 0)
  ) u_edge (
    .clk   (clk),
    .rstn  (rstn),
    .btn_i (i_btn),
    .pe_o  (pe),
    .ne_o  (ne)
  );

`ifdef BUTTON_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_CYCLES - 1);
  logic repeat_q, repeat_d;
`endif

  // Next-state, event decisions and interval counter.
  always_comb begin
    state_d  = state_q;
    click_d  = 1'b0;
    dclick_d = 1'b0;
    long_d   = 1'b0;
    cnt_clr  = 1'b0;
`ifdef BUTTON_AUTOREPEAT_EN
    repeat_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (pe) state_d = PRESSED1;
      end
      PRESSED1: begin
        // Release beats the long threshold when both land on the same edge.
        if (ne) begin
          state_d = WAIT2;
        end else if (cnt_q == LONG_LAST) begin
          state_d = LONG_HELD;
          long_d  = 1'b1;
        end
      end
      WAIT2: begin
        // A second press beats the gap timeout when both land together.
        if (pe) begin
          state_d = PRESSED2;
        end else if (cnt_q == GAP_LAST) begin
          state_d = IDLE;
          click_d = 1'b1;
        end
      end
      PRESSED2: begin
        if (ne) begin
          state_d  = IDLE;
          dclick_d = 1'b1;
        end
      end
      LONG_HELD: begin
        if (ne) begin
          state_d = IDLE;
        end
`ifdef BUTTON_AUTOREPEAT_EN
        else if (cnt_q == REP_LAST) begin
          repeat_d = 1'b1;
          cnt_clr  = 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
    if (state_d != state_q) cnt_clr = 1'b1;
    if (cnt_clr)      cnt_d = '0;
    else if (&cnt_q)  cnt_d = cnt_q;
    else              cnt_d = cnt_q + CNT_W'(1);
  end

  // State, counter and registered event outputs.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      click_q   <= 1'b0;
      dclick_q  <= 1'b0;
      long_q    <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      press_q   <= pe;
      release_q <= ne;
      click_q   <= click_d;
      dclick_q  <= dclick_d;
      long_q    <= long_d;
      held_q    <= (state_d == LONG_HELD);
    end
  end

`ifdef BUTTON_AUTOREPEAT_EN
  // Registered auto-repeat pulse.
  always_ff @(posedge clk) begin
    if (!rstn) repeat_q <= 1'b0;
    else       repeat_q <= repeat_d;
  end
  assign o_repeat = repeat_q;
`else
  assign o_repeat = 1'b0;
`endif

  assign o_press   = press_q;
  assign o_release = release_q;
  assign o_click   = click_q;
  assign o_dclick  = dclick_q;
  assign o_long    = long_q;
  assign o_held    = held_q;

endmodule
